// File: rtl/smi_dir_arbiter_pkg.sv
// rtl/smi_dir_arbiter_pkg.sv - shared state codes and direction constants for the SMI direction arbiter
// Purpose: one place for the FSM state encoding (also exported on o_state for debug)
//          and the bus direction encoding used by the arbiter.
// Ports:   none (package).
package smi_dir_arbiter_pkg;

  typedef enum logic [2:0] {
    S_RX       = 3'd0,
    S_RX_DRAIN = 3'd1,
    S_TURN     = 3'd2,
    S_TX       = 3'd3,
    S_TX_DRAIN = 3'd4
  } state_e;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

endpackage

// File: rtl/smi_dir_arbiter_level_debouncer.sv
// rtl/smi_dir_arbiter_level_debouncer.sv - synchroniser plus level debouncer for the host direction pin
// Purpose: brings the asynchronous direction request into the clock domain and only
//          accepts a new level after it has held for DEB_CYCLES consecutive cycles.
// Ports:   clk_i   - system clock
//          rst_i   - synchronous active-high reset
//          pin_i   - raw asynchronous pin
//          level_o - debounced level
module smi_dir_arbiter_level_debouncer #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      // Any cycle that agrees with the accepted level restarts the qualification window,
      // so a glitch shorter than DEB_CYCLES leaves no residue.
      if (s == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_q <= s;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/smi_dir_arbiter.sv
// rtl/smi_dir_arbiter.sv - direction owner for the shared SMI data bus
// Purpose: drains the active path, holds a turnaround guard with both paths disabled,
//          then enables the path the host asked for.
// Ports:   i_sys_clk, i_rst     - clock, synchronous active-high reset
//          i_dir_req            - raw host direction pin (1 = TX, 0 = RX)
//          i_rx_busy, i_tx_busy - datapath word-in-flight flags
//          o_dir                - pad direction (1 = TX / pads input)
//          o_rx_en, o_tx_en     - path enables
//          o_turnaround         - guard interval flag
//          o_state              - FSM state code (debug)
//          o_switch_count       - completed direction switches, saturating
module smi_dir_arbiter
  import smi_dir_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int TURN_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic        i_sys_clk,
  input  logic        i_rst,
  input  logic        i_dir_req,
  input  logic        i_rx_busy,
  input  logic        i_tx_busy,
  output logic        o_dir,
  output logic        o_rx_en,
  output logic        o_tx_en,
  output logic        o_turnaround,
  output logic [2:0]  o_state,
  output logic [15:0] o_switch_count
);

  logic             deb_level;
  state_e           state_q, state_d;
  logic             tgt_q, tgt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  // Set while the turnaround in progress is the one following reset; that one is not a switch.
  logic             boot_q, boot_d;
  logic             count_inc;
  logic [15:0]      sw_cnt_q;
  logic             dir_q, rx_en_q, tx_en_q, turn_q;

  smi_dir_arbiter_level_debouncer #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES),
    .CNT_W       (CNT_W)
  ) u_deb (
    .clk_i   (i_sys_clk),
    .rst_i   (i_rst),
    .pin_i   (i_dir_req),
    .level_o (deb_level)
  );

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    tcnt_d    = tcnt_q;
    boot_d    = boot_q;
    count_inc = 1'b0;
    case (state_q)
      S_RX: if (deb_level) state_d = S_RX_DRAIN;
      S_RX_DRAIN: begin
        // A reverted request beats a simultaneous busy drop.
        if (!deb_level) begin
          state_d = S_RX;
        end else if (!i_rx_busy) begin
          state_d = S_TURN;
          tgt_d   = DIR_TX;
          tcnt_d  = CNT_W'(TURN_CYCLES - 1);
        end
      end
      S_TX: if (!deb_level) state_d = S_TX_DRAIN;
      S_TX_DRAIN: begin
        if (deb_level) begin
          state_d = S_TX;
        end else if (!i_tx_busy) begin
          state_d = S_TURN;
          tgt_d   = DIR_RX;
          tcnt_d  = CNT_W'(TURN_CYCLES - 1);
        end
      end
      S_TURN: begin
        // deb_level is deliberately not looked at here; the destination state re-evaluates it.
        if (tcnt_q == '0) begin
          state_d   = tgt_q ? S_TX : S_RX;
          count_inc = !boot_q;
          boot_d    = 1'b0;
        end else begin
          tcnt_d = tcnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_TURN;
        tgt_d   = DIR_RX;
        tcnt_d  = CNT_W'(TURN_CYCLES - 1);
      end
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q  <= S_TURN;
      tgt_q    <= DIR_RX;
      tcnt_q   <= CNT_W'(TURN_CYCLES - 1);
      boot_q   <= 1'b1;
      sw_cnt_q <= '0;
      dir_q    <= DIR_RX;
      rx_en_q  <= 1'b0;
      tx_en_q  <= 1'b0;
      turn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      tcnt_q  <= tcnt_d;
      boot_q  <= boot_d;
      if (count_inc && (sw_cnt_q != 16'hFFFF)) sw_cnt_q <= sw_cnt_q + 16'd1;
      // Outputs decode the next state so they line up with the state register.
      rx_en_q <= (state_d == S_RX);
      tx_en_q <= (state_d == S_TX);
      turn_q  <= (state_d == S_TURN);
      if ((state_d == S_TURN) && (state_q != S_TURN)) dir_q <= tgt_d;
    end
  end

  assign o_dir          = dir_q;
  assign o_rx_en        = rx_en_q;
  assign o_tx_en        = tx_en_q;
  assign o_turnaround   = turn_q;
  assign o_state        = state_q;
  assign o_switch_count = sw_cnt_q;

endmodule

// File: tb/tb_smi_dir_arbiter.sv
// tb/tb_smi_dir_arbiter.sv - directed self-checking bench for smi_dir_arbiter
module tb_smi_dir_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        dir_req;
  logic        rx_busy;
  logic        tx_busy;
  logic        dir;
  logic        rx_en;
  logic        tx_en;
  logic        turn;
  logic [2:0]  state;
  logic [15:0] sw_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  smi_dir_arbiter #(
    .SYNC_STAGES (2),
    .DEB_CYCLES  (16),
    .TURN_CYCLES (4),
    .CNT_W       (8)
  ) dut (
    .i_sys_clk      (clk),
    .i_rst          (rst),
    .i_dir_req      (dir_req),
    .i_rx_busy      (rx_busy),
    .i_tx_busy      (tx_busy),
    .o_dir          (dir),
    .o_rx_en        (rx_en),
    .o_tx_en        (tx_en),
    .o_turnaround   (turn),
    .o_state        (state),
    .o_switch_count (sw_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic d, input logic re,
                         input logic te, input logic tu, input logic [15:0] cnt);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".dir"},   32'(dir),   32'(d));
    chk({tag, ".rx_en"}, 32'(rx_en), 32'(re));
    chk({tag, ".tx_en"}, 32'(tx_en), 32'(te));
    chk({tag, ".turn"},  32'(turn),  32'(tu));
    chk({tag, ".count"}, 32'(sw_cnt), 32'(cnt));
  endtask

  // Enables must never overlap and must both be low whenever the direction flips.
  logic prev_dir = 1'b0;
  always @(negedge clk) begin
    chk("excl_en", 32'(rx_en & tx_en), 32'd0);
    if (dir !== prev_dir) chk("en_at_dir_change", 32'(rx_en | tx_en), 32'd0);
    prev_dir <= dir;
  end

  initial begin
    rst     = 1'b1;
    dir_req = 1'b0;
    rx_busy = 1'b0;
    tx_busy = 1'b0;
    tick(3);
    chk_out("reset", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);

    // Reset-exit turnaround: 4 cycles, no count.
    rst = 1'b0;
    tick(3);
    chk_out("boot_turn", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    tick(1);
    chk_out("boot_rx", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

    // 15-cycle glitch is ignored.
    dir_req = 1'b1;
    tick(15);
    dir_req = 1'b0;
    tick(2);
    chk_out("glitch_mid", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    tick(6);
    chk_out("glitch_after", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

    // RX -> TX with rx_busy low.
    dir_req = 1'b1;
    tick(18);
    chk("sw1_e18.state", 32'(state), 32'd0);
    tick(1);
    chk_out("sw1_e19", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    tick(1);
    chk_out("sw1_e20", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
    tick(3);
    chk_out("sw1_e23", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
    tick(1);
    chk_out("sw1_e24", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);

    // TX drain held by tx_busy, then request returns to TX.
    tx_busy = 1'b1;
    dir_req = 1'b0;
    tick(19);
    chk_out("txdrain", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    dir_req = 1'b1;
    tick(18);
    chk_out("txdrain_hold", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    tick(1);
    chk_out("txdrain_abort", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
    tx_busy = 1'b0;

    // TX -> RX.
    dir_req = 1'b0;
    tick(24);
    chk_out("sw2", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);

    // RX drain held by rx_busy for 10 cycles.
    rx_busy = 1'b1;
    dir_req = 1'b1;
    tick(19);
    chk_out("rxdrain", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    tick(10);
    chk_out("rxdrain_hold", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    rx_busy = 1'b0;
    tick(1);
    chk_out("rxdrain_turn", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2);
    tick(4);
    chk_out("sw3", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3);

    // Saturation of the switch counter.
    force dut.sw_cnt_q = 16'hFFFE;
    tick(1);
    release dut.sw_cnt_q;
    tick(1);
    chk("sat_preload", 32'(sw_cnt), 32'h0000FFFE);
    dir_req = 1'b0;
    tick(24);
    chk_out("sat_first", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    dir_req = 1'b1;
    tick(24);
    chk_out("sat_hold", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF);

    // Reset in the middle of S_TX.
    rst     = 1'b1;
    dir_req = 1'b0;
    tick(1);
    chk_out("midrst", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    rst = 1'b0;
    tick(3);
    chk_out("midrst_turn", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    tick(1);
    chk_out("midrst_rx", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
